instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Upstream stage of exe_engine. Holds a small program of 5-bit instructions and
//   issues them one at a time on instr. It waits for exe_engine to report completion
//   before advancing the program counter. It stops on a HALT opcode or at the end of
//   program memory.
//   Instruction format: [4:2] opcode, [1:0] flags (passed through unchanged).
//   Opcodes: 000 add, 001 sub, 010 scale, 011 mult, 100 transpose, 111 halt;
//   101 and 110 are illegal.
// PARAMETERS
//   DEPTH  16  program memory entries
//   AW     4   address / pc width; DEPTH == 2**AW
//   IW     5   instruction width; fixed to match exe_engine
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   load_en      in   1   write load_data into program memory at load_addr
//   load_addr    in   AW  program memory write address
//   load_data    in   IW  instruction to write
//   start        in   1   pulse: begin execution at address 0
//   exe_done     in   1   exe_engine has finished the current instruction
//   instr        out  IW  instruction presented to exe_engine (registered)
//   instr_valid  out  1   one-cycle pulse: instr is newly issued
//   pc           out  AW  address of current or last-fetched instruction
//   busy         out  1   high in FETCH, ISSUE and WAIT
//   halted       out  1   high in HALT
//   err          out  1   sticky: illegal opcode encountered since last start
// BEHAVIOUR
//   Reset (reset==0, async): state IDLE, instr=5'b00000, instr_valid=0, pc=0,
//     busy=0, halted=0, err=0. Program memory is NOT cleared.
//   Reset mid-run aborts immediately. No exe_done is awaited afterwards.
//   FSM: IDLE -> FETCH -> ISSUE -> WAIT -> FETCH ... | HALT.
//   IDLE or HALT, start=1: pc<=0, err<=0, halted<=0, go to FETCH.
//   FETCH: decode mem[pc].
//     - halt (111): go to HALT. instr is not updated and not issued.
//     - illegal (101/110): err<=1, not issued, treated as a NOP (advance rule below).
//     - otherwise: instr<=mem[pc], instr_valid<=1, go to ISSUE.
//   ISSUE (1 cycle, instr_valid high): instr_valid<=0, go to WAIT.
//   WAIT: hold instr stable until exe_done==1, then apply the advance rule.
//   Advance rule: if pc==DEPTH-1, go to HALT (no wrap); else pc<=pc+1 and go to FETCH.
//   Latency: start sampled at edge k -> instr and instr_valid update at edge k+1 and
//     are seen in cycle k+1.
//   Steady-state throughput: one instruction per (exe latency + 2) cycles.
//   exe_done is sampled only in WAIT. It is ignored in every other state, including
//     the ISSUE cycle.
//   start is ignored while busy.
//   load_en is honoured only in IDLE/HALT and ignored while busy.
//   load_en and start together in IDLE: the write lands at the same edge, so FETCH
//     sees the new data.
//   In HALT: instr holds the last issued value; pc holds the halting or last address.
// TESTING
//   1. Load add(00011), sub(00111), halt(11100); start; exe_done 2 cycles after each
//      pulse -> two instr_valid pulses carrying 00011 then 00111; halted=1, pc=2,
//      err=0.
//   2. Load all 16 entries as scale(01011) with no halt; start -> 16 pulses, no wrap;
//      halted=1, pc=15.
//   3. Program {10111, 01111, 11100} -> err=1; exactly one pulse (01111); halted=1.
//   4. Assert reset low during WAIT of instr 1 -> outputs go to reset values at once;
//      a later start re-runs from pc=0.
//   5. Pulse exe_done during ISSUE and pulse start while busy -> both ignored; pc
//      unchanged until exe_done arrives in WAIT.
//   6. load_en to address 0 while busy -> memory unchanged; the same write in HALT,
//      then start -> the new instruction is issued first.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: small program store plus issue FSM feeding exe_engine.
// Issues one instruction, waits for exe_done, then advances until HALT or end of memory.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          exe_done,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [2:0]    OP_BAD0 = 3'b101;
    localparam logic [2:0]    OP_BAD1 = 3'b110;
    localparam logic [2:0]    OP_HALT = 3'b111;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] pc_n;
    logic [IW-1:0] instr_n;
    logic          valid_n;
    logic          err_n;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] fetched;
    logic [2:0]    opcode;
    logic          op_halt;
    logic          op_illegal;
    logic          at_end;
    logic          idle_or_halt;

    assign idle_or_halt = (state == S_IDLE) || (state == S_HALT);
    assign busy         = (state == S_FETCH) || (state == S_ISSUE) ||
                          (state == S_WAIT);
    assign halted       = (state == S_HALT);
    assign at_end       = (pc == LAST);

    // Program store is deliberately left out of reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (load_en && idle_or_halt)
            mem[load_addr] <= load_data;
    end

    assign fetched = mem[pc];
    assign opcode  = fetched[IW-1 -: 3];

    always_comb begin
        op_halt    = 1'b0;
        op_illegal = 1'b0;
        unique case (opcode)
            OP_HALT:          op_halt    = 1'b1;
            OP_BAD0, OP_BAD1: op_illegal = 1'b1;
            default:          ;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        valid_n = 1'b0;
        err_n   = err;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n    = '0;
                    err_n   = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (op_halt) begin
                    state_n = S_HALT;
                end else if (op_illegal) begin
                    err_n = 1'b1;
                    if (at_end) begin
                        state_n = S_HALT;
                    end else begin
                        pc_n    = pc + AW'(1);
                        state_n = S_FETCH;
                    end
                end else begin
                    instr_n = fetched;
                    valid_n = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (exe_done) begin
                    if (at_end) begin
                        state_n = S_HALT;
                    end else begin
                        pc_n    = pc + AW'(1);
                        state_n = S_FETCH;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: program table runs plus hand-built abort, ignore and load cases.
// Issued instructions are checked against a queue of expected values.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [3:0] load_addr;
    logic [4:0] load_data;
    logic       start;
    logic       exe_done;
    logic [4:0] instr;
    logic       instr_valid;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [4:0] expq[$];
    logic [4:0] e;

    logic auto_en  = 1'b0;
    logic auto_done = 1'b0;
    logic man_done = 1'b0;
    int   exe_lat  = 2;
    int   cnt      = 0;

    assign exe_done = auto_done | man_done;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .exe_done   (exe_done),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err)
    );

    typedef struct packed {
        logic [15:0][4:0] prog;
        logic [4:0]       n;
        logic [15:0][4:0] exp;
        logic [4:0]       n_exp;
        logic [3:0]       pc;
        logic             err;
    } vec_t;

    vec_t vecs[4];

    always @(negedge clk) begin
        if (reset && instr_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected instr %b", instr);
            end else begin
                e = expq.pop_front();
                if (instr !== e) begin
                    errors++;
                    $display("FAIL pulse: instr %b expected %b", instr, e);
                end
            end
        end
    end

    // Models exe_engine: completes exe_lat cycles after each issue pulse.
    always @(negedge clk) begin
        if (!auto_en) begin
            auto_done = 1'b0;
            cnt = 0;
        end else if (auto_done) begin
            auto_done = 1'b0;
        end else if (instr_valid) begin
            cnt = exe_lat;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) auto_done = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [4:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, " halt reached"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " issue seen"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        for (int i = 0; i < 32'(v.n); i++)
            load(4'(i), v.prog[i]);
        for (int i = 0; i < 32'(v.n_exp); i++)
            expq.push_back(v.exp[i]);
        pulse_start();
        wait_halt(name);
        chk({name, " pc"}, 32'(pc), 32'(v.pc));
        chk({name, " err"}, 32'(err), 32'(v.err));
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " pulses left"}, expq.size(), 32'd0);
        chk({name, " instr held"}, 32'(instr), 32'(v.exp[v.n_exp - 1]));
    endtask

    initial begin
        vecs[0] = '0;
        vecs[0].prog[0] = 5'b00011;
        vecs[0].prog[1] = 5'b00111;
        vecs[0].prog[2] = 5'b11100;
        vecs[0].n = 5'd3;
        vecs[0].exp[0] = 5'b00011;
        vecs[0].exp[1] = 5'b00111;
        vecs[0].n_exp = 5'd2;
        vecs[0].pc = 4'd2;
        vecs[0].err = 1'b0;

        vecs[1] = '0;
        vecs[1].prog[0] = 5'b10111;
        vecs[1].prog[1] = 5'b01111;
        vecs[1].prog[2] = 5'b11100;
        vecs[1].n = 5'd3;
        vecs[1].exp[0] = 5'b01111;
        vecs[1].n_exp = 5'd1;
        vecs[1].pc = 4'd2;
        vecs[1].err = 1'b1;

        vecs[2] = '0;
        for (int i = 0; i < 16; i++) begin
            vecs[2].prog[i] = 5'b01011;
            vecs[2].exp[i] = 5'b01011;
        end
        vecs[2].n = 5'd16;
        vecs[2].n_exp = 5'd16;
        vecs[2].pc = 4'd15;
        vecs[2].err = 1'b0;

        vecs[3] = '0;
        vecs[3].prog[0] = 5'b00000;
        vecs[3].prog[1] = 5'b10000;
        vecs[3].prog[2] = 5'b11001;
        vecs[3].prog[3] = 5'b00110;
        vecs[3].prog[4] = 5'b11100;
        vecs[3].n = 5'd5;
        vecs[3].exp[0] = 5'b00000;
        vecs[3].exp[1] = 5'b10000;
        vecs[3].exp[2] = 5'b00110;
        vecs[3].n_exp = 5'd3;
        vecs[3].pc = 4'd4;
        vecs[3].err = 1'b1;

        reset = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset instr", 32'(instr), 32'd0);
        chk("reset valid", 32'(instr_valid), 32'd0);
        chk("reset pc", 32'(pc), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 1'b1;
        auto_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting on the first issued instruction.
        load(4'd0, 5'b11000);
        load(4'd1, 5'b00011);
        load(4'd2, 5'b00111);
        load(4'd3, 5'b11100);
        exe_lat = 6;
        expq.push_back(5'b00011);
        pulse_start();
        wait_valid("t4");
        @(negedge clk);
        @(negedge clk);
        chk("t4 wait pc", 32'(pc), 32'd1);
        chk("t4 err before", 32'(err), 32'd1);
        reset = 1'b0;
        auto_en = 1'b0;
        #1;
        chk("t4 rst instr", 32'(instr), 32'd0);
        chk("t4 rst valid", 32'(instr_valid), 32'd0);
        chk("t4 rst pc", 32'(pc), 32'd0);
        chk("t4 rst busy", 32'(busy), 32'd0);
        chk("t4 rst halted", 32'(halted), 32'd0);
        chk("t4 rst err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        auto_en = 1'b1;
        exe_lat = 2;
        repeat (3) @(negedge clk);
        chk("t4 stays idle", 32'({busy, halted}), 32'd0);
        expq.push_back(5'b00011);
        expq.push_back(5'b00111);
        pulse_start();
        wait_halt("t4 rerun");
        chk("t4 rerun pc", 32'(pc), 32'd3);
        chk("t4 rerun err", 32'(err), 32'd1);

        // exe_done in ISSUE and start while busy must be ignored.
        load(4'd0, 5'b00011);
        load(4'd1, 5'b00111);
        load(4'd2, 5'b11100);
        auto_en = 1'b0;
        expq.push_back(5'b00011);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5 fetch busy", 32'(busy), 32'd1);
        chk("t5 fetch no valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("t5 issue valid", 32'(instr_valid), 32'd1);
        man_done = 1'b1;
        start = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("t5 pc held", 32'(pc), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5 pc still held", 32'(pc), 32'd0);
        chk("t5 still busy", 32'(busy), 32'd1);
        expq.push_back(5'b00111);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("t5 advanced", 32'(pc), 32'd1);
        auto_en = 1'b1;
        wait_halt("t5");
        chk("t5 pc", 32'(pc), 32'd2);
        chk("t5 pulses left", expq.size(), 32'd0);

        // Loads while busy are dropped; loads in HALT land.
        exe_lat = 4;
        expq.push_back(5'b00011);
        expq.push_back(5'b00111);
        pulse_start();
        wait_valid("t6");
        @(negedge clk);
        load(4'd0, 5'b10001);
        wait_halt("t6 busy load");
        expq.push_back(5'b00011);
        expq.push_back(5'b00111);
        pulse_start();
        wait_halt("t6 rerun");
        chk("t6 rerun pulses left", expq.size(), 32'd0);
        load(4'd0, 5'b10001);
        expq.push_back(5'b10001);
        expq.push_back(5'b00111);
        pulse_start();
        wait_halt("t6 halt load");
        chk("t6 halt load pulses left", expq.size(), 32'd0);

        // Load and start on the same edge from IDLE.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expq.push_back(5'b01100);
        expq.push_back(5'b00111);
        load_en = 1'b1;
        load_addr = 4'd0;
        load_data = 5'b01100;
        start = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        start = 1'b0;
        wait_halt("t7");
        chk("t7 pulses left", expq.size(), 32'd0);
        chk("t7 instr", 32'(instr), 32'h07);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
